// File: rtl/led_color_sequencer.sv
// Palette-driven RGB565 colour scheduler for the LED PWM block.
// Define LED_SEQ_FADE_EN to build in the per-channel crossfade between entries.
module led_color_sequencer #(
    parameter int DEPTH       = 4,
    parameter int STEP_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [15:0]                wr_color,
    input  logic [$clog2(DEPTH)-1:0]   last_idx,
    input  logic [15:0]                hold_cycles,
    output logic [15:0]                color,
    output logic [$clog2(DEPTH)-1:0]   idx,
    output logic                       busy,
    output logic                       step_pulse
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        HOLD
`ifdef LED_SEQ_FADE_EN
        , FADE
`endif
    } state_t;

    state_t          state;
    logic [15:0]     palette [DEPTH];
    logic [15:0]     hold_cnt;
    logic [15:0]     hold_len;
    logic            hold_done;
    logic [AW-1:0]   next_idx;
    logic            wr_en;

    assign hold_len  = (hold_cycles == 16'd0) ? 16'd1 : hold_cycles;
    assign hold_done = (hold_cnt >= hold_len - 16'd1);
    assign next_idx  = (idx == last_idx) ? '0 : idx + AW'(1);
    assign wr_en     = wr_valid & wr_ready;

`ifdef LED_SEQ_FADE_EN
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    logic [15:0]   target;
    logic [AW-1:0] fade_idx;
    logic [SW-1:0] step_cnt;

    // One LSB toward the target, never past it.
    function automatic logic [5:0] ch_step(input logic [5:0] c, input logic [5:0] t);
        if (c < t) return c + 6'd1;
        if (c > t) return c - 6'd1;
        return c;
    endfunction

    function automatic logic [15:0] fade_step(input logic [15:0] c, input logic [15:0] t);
        logic [5:0] r, g, b;
        r = ch_step({1'b0, c[15:11]}, {1'b0, t[15:11]});
        g = ch_step(c[10:5], t[10:5]);
        b = ch_step({1'b0, c[4:0]}, {1'b0, t[4:0]});
        return {r[4:0], g, b[4:0]};
    endfunction

    assign wr_ready = ~rst & (state != FADE);
`else
    logic [31:0] unused_step;
    assign unused_step = STEP_CYCLES;
    assign wr_ready    = ~rst;
`endif

    // Palette storage; an entry load on the same edge sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) palette[i] <= 16'h0000;
        end else if (wr_en) begin
            palette[wr_addr] <= wr_color;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            color      <= 16'h0000;
            idx        <= '0;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
            hold_cnt   <= 16'd0;
`ifdef LED_SEQ_FADE_EN
            target     <= 16'h0000;
            fade_idx   <= '0;
            step_cnt   <= '0;
`endif
        end else begin
            step_pulse <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                color    <= 16'h0000;
                idx      <= '0;
                busy     <= 1'b0;
                hold_cnt <= 16'd0;
            end else begin
                case (state)
                    IDLE: begin
                        color    <= palette[0];
                        idx      <= '0;
                        hold_cnt <= 16'd0;
                        busy     <= 1'b1;
                        state    <= HOLD;
                    end
                    HOLD: begin
                        if (hold_done) begin
                            hold_cnt <= 16'd0;
`ifdef LED_SEQ_FADE_EN
                            // Equal colours skip the fade and advance at once.
                            if (palette[next_idx] != color) begin
                                target   <= palette[next_idx];
                                fade_idx <= next_idx;
                                step_cnt <= '0;
                                state    <= FADE;
                            end else begin
                                idx        <= next_idx;
                                step_pulse <= 1'b1;
                            end
`else
                            color      <= palette[next_idx];
                            idx        <= next_idx;
                            step_pulse <= 1'b1;
`endif
                        end else begin
                            hold_cnt <= hold_cnt + 16'd1;
                        end
                    end
`ifdef LED_SEQ_FADE_EN
                    FADE: begin
                        if (color == target) begin
                            idx        <= fade_idx;
                            step_pulse <= 1'b1;
                            hold_cnt   <= 16'd0;
                            state      <= HOLD;
                        end else if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            color    <= fade_step(color, target);
                        end else begin
                            step_cnt <= step_cnt + SW'(1);
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_color_sequencer.sv
// Self-checking bench for led_color_sequencer: tables, corner sequences and a random run.
module tb_led_color_sequencer;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_color;
    logic [AW-1:0] last_idx;
    logic [15:0]   hold_cycles;
    logic [15:0]   color;
    logic [AW-1:0] idx;
    logic          busy;
    logic          step_pulse;

    int n_checks = 0;
    int n_errors = 0;

    led_color_sequencer #(.DEPTH(DEPTH), .STEP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_color(wr_color),
        .last_idx(last_idx), .hold_cycles(hold_cycles),
        .color(color), .idx(idx), .busy(busy), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [15:0]   color;
        logic [AW-1:0] idx;
        logic          sp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pal(input logic [AW-1:0] a, input logic [15:0] v);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_color = v;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        int pulses;
        logic [15:0] m_pal [DEPTH];
        logic [15:0] m_color;
        logic [15:0] exp_c;
        int m_idx, m_age, hl;
        bit m_run, m_sp;

        rst = 1'b1; enable = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_color = '0;
        last_idx = '0; hold_cycles = '0;
        #12;
        check("reset_color", color, 0);
        check("reset_idx", idx, 0);
        check("reset_busy", busy, 0);
        check("reset_step", step_pulse, 0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Asynchronous reset in the middle of a hold
        write_pal(0, 16'h1111); write_pal(1, 16'h2222);
        write_pal(2, 16'hF800); write_pal(3, 16'h3333);
        last_idx = 3; hold_cycles = 3; enable = 1'b1;
        for (int i = 0; i < 300 && idx != 2; i++) tick();
        check("reach_idx2", idx, 2);
        check("idx2_color", color, 16'hF800);
        #2 rst = 1'b1;
        #1;
        check("async_rst_color", color, 0);
        check("async_rst_idx", idx, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_step", step_pulse, 0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("post_rst_color", color, 16'h0000);
        check("post_rst_busy", busy, 1);
        check("post_rst_ready", wr_ready, 1);

        // Enable drop after a same-colour advance; palette retained
        enable = 1'b0; tick();
        write_pal(0, 16'h1234); write_pal(1, 16'h1234);
        last_idx = 1; hold_cycles = 2; enable = 1'b1;
        tick(); check("en_c1_color", color, 16'h1234);
        tick(); tick();
        check("en_c3_idx", idx, 1);
        check("en_c3_step", step_pulse, 1);
        check("en_c3_color", color, 16'h1234);
        tick();
        check("en_c4_step", step_pulse, 0);
        enable = 1'b0; tick();
        check("drop_color", color, 0);
        check("drop_busy", busy, 0);
        check("drop_idx", idx, 0);
        check("drop_step", step_pulse, 0);
        enable = 1'b1; tick();
        check("reen_color", color, 16'h1234);
        check("reen_busy", busy, 1);
        enable = 1'b0; tick();

`ifndef LED_SEQ_FADE_EN
        // Four-entry sequence, hold 10
        tbl[0] = '{1,  16'hF800, 2'd0, 1'b0};
        tbl[1] = '{10, 16'hF800, 2'd0, 1'b0};
        tbl[2] = '{11, 16'h07E0, 2'd1, 1'b1};
        tbl[3] = '{12, 16'h07E0, 2'd1, 1'b0};
        tbl[4] = '{20, 16'h07E0, 2'd1, 1'b0};
        tbl[5] = '{21, 16'h001F, 2'd2, 1'b1};
        tbl[6] = '{31, 16'h0821, 2'd3, 1'b1};
        tbl[7] = '{40, 16'h0821, 2'd3, 1'b0};
        tbl[8] = '{41, 16'hF800, 2'd0, 1'b1};
        tbl[9] = '{50, 16'hF800, 2'd0, 1'b0};
        write_pal(0, 16'hF800); write_pal(1, 16'h07E0);
        write_pal(2, 16'h001F); write_pal(3, 16'h0821);
        last_idx = 3; hold_cycles = 10; enable = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c >= 11 && step_pulse) pulses++;
            for (int k = 0; k < 10; k++) begin
                if (tbl[k].cyc == c) begin
                    check("seq_color", color, tbl[k].color);
                    check("seq_idx", idx, tbl[k].idx);
                    check("seq_step", step_pulse, tbl[k].sp);
                end
            end
        end
        check("seq_pulse_count", pulses, 4);

        // hold_cycles = 0 toggles every cycle
        enable = 1'b0; tick();
        write_pal(0, 16'h0001); write_pal(1, 16'h0002);
        last_idx = 1; hold_cycles = 0; enable = 1'b1;
        tick(); check("h0_c1_color", color, 16'h0001);
        for (int c = 2; c <= 7; c++) begin
            tick();
            check("h0_color", color, (c % 2 == 0) ? 16'h0002 : 16'h0001);
            check("h0_step", step_pulse, 1);
        end

        // last_idx = 0 reloads the same entry
        enable = 1'b0; tick();
        last_idx = 0; hold_cycles = 3; enable = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check("l0_color", color, 16'h0001);
            check("l0_idx", idx, 0);
            check("l0_step", step_pulse, (c > 1 && (c - 1) % 3 == 0) ? 1 : 0);
        end

        // Write to the entry being loaded on the same edge
        enable = 1'b0; tick();
        write_pal(0, 16'h0101); write_pal(1, 16'h07E0);
        write_pal(2, 16'h0202); write_pal(3, 16'h0303);
        last_idx = 3; hold_cycles = 3; enable = 1'b1;
        tick(); tick(); tick();
        wr_valid = 1'b1; wr_addr = 1; wr_color = 16'h001F;
        tick();
        wr_valid = 1'b0;
        check("coll_color_old", color, 16'h07E0);
        check("coll_idx", idx, 1);
        check("coll_step", step_pulse, 1);
        for (int i = 0; i < 12; i++) tick();
        check("coll_revisit_idx", idx, 1);
        check("coll_color_new", color, 16'h001F);

        // Random run against a reference model
        enable = 1'b0; tick();
        for (int a = 0; a < DEPTH; a++) begin
            m_pal[a] = 16'($urandom);
            write_pal(AW'(a), m_pal[a]);
        end
        m_run = 0; m_idx = 0; m_age = 0; m_color = 0; m_sp = 0;
        hold_cycles = 2; last_idx = 3;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 3) enable = ~enable;
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_addr  = AW'($urandom);
            wr_color = 16'($urandom);
            if ($urandom_range(0, 49) == 0) hold_cycles = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) last_idx = AW'($urandom);
            if (!enable) begin
                m_run = 0; m_color = 0; m_idx = 0; m_sp = 0;
            end else if (!m_run) begin
                m_run = 1; m_color = m_pal[0]; m_idx = 0; m_age = 0; m_sp = 0;
            end else begin
                m_age++;
                hl = (hold_cycles == 0) ? 1 : int'(hold_cycles);
                m_sp = 0;
                if (m_age >= hl) begin
                    m_idx   = (m_idx == int'(last_idx)) ? 0 : (m_idx + 1) % DEPTH;
                    m_color = m_pal[m_idx];
                    m_age   = 0;
                    m_sp    = 1;
                end
            end
            if (wr_valid) m_pal[wr_addr] = wr_color;
            tick();
            check("rnd_color", color, m_color);
            check("rnd_idx", idx, m_idx);
            check("rnd_step", step_pulse, m_sp);
            check("rnd_busy", busy, m_run);
        end
        wr_valid = 1'b0;
`else
        // Red ramp up and back down with STEP_CYCLES = 2
        write_pal(0, 16'h0000); write_pal(1, 16'hF800);
        last_idx = 1; hold_cycles = 5; enable = 1'b1;
        for (int c = 1; c <= 137; c++) begin
            tick();
            if (c <= 69) begin
                if (c <= 5)       exp_c = 16'h0000;
                else if (c <= 68) exp_c = 16'((c - 6) / 2) << 11;
                else              exp_c = 16'hF800;
                check("fade_color", color, exp_c);
                check("fade_idx", idx, (c == 69) ? 1 : 0);
                check("fade_step", step_pulse, (c == 69) ? 1 : 0);
                check("fade_ready", wr_ready, (c >= 6 && c <= 68) ? 0 : 1);
            end
            if (c == 20) begin
                wr_valid = 1'b1; wr_addr = 0; wr_color = 16'h1234;
            end
            if (c == 21) wr_valid = 1'b0;
            if (c == 137) begin
                check("fadedown_color", color, 16'h0000);
                check("fadedown_idx", idx, 0);
                check("fadedown_step", step_pulse, 1);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
